// File: rtl/alu_pkg.sv
// Shared definitions for the multi-cycle ALU: op codes, FSM states and flag layout.
package alu_pkg;

  localparam logic [2:0] OP_AND = 3'd0;
  localparam logic [2:0] OP_OR  = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_SUB = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_SLT = 3'd5;
  localparam logic [2:0] OP_MUL = 3'd6;
  localparam logic [2:0] OP_DIV = 3'd7;

  typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DONE} state_t;

  localparam int unsigned FLAG_ZERO  = 0;
  localparam int unsigned FLAG_CARRY = 1;
  localparam int unsigned FLAG_OVF   = 2;
  localparam int unsigned FLAG_W     = 3;

  function automatic logic [FLAG_W-1:0] pack_flags(input logic zero, input logic carry,
                                                   input logic ovf);
    logic [FLAG_W-1:0] f;
    f             = '0;
    f[FLAG_ZERO]  = zero;
    f[FLAG_CARRY] = carry;
    f[FLAG_OVF]   = ovf;
    return f;
  endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative unsigned multiply (shift-add) and restoring divide sharing one adder and
// one shift register pair. Outputs show the value produced by the current step.
module alu_muldiv_iter #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product_lo,
  output logic [WIDTH-1:0] product_hi,
  output logic [WIDTH-1:0] quotient
);

  logic [WIDTH-1:0] hi_q, lo_q, b_q;
  logic [WIDTH-1:0] hi_d, lo_d;
  logic             div_q, busy_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH:0]   x;
  logic [WIDTH+1:0] y, s;
  logic             cin, ge;

  // Divide subtracts b from the shifted partial remainder; multiply adds b when the
  // multiplier LSB is set. Both go through the same WIDTH+2-bit adder.
  always_comb begin
    if (div_q) begin
      x   = {hi_q, lo_q[WIDTH-1]};
      y   = ~{2'b00, b_q};
      cin = 1'b1;
    end else begin
      x   = {1'b0, hi_q};
      y   = {2'b00, (lo_q[0] ? b_q : {WIDTH{1'b0}})};
      cin = 1'b0;
    end
    s  = {1'b0, x} + y + {{(WIDTH+1){1'b0}}, cin};
    ge = ~s[WIDTH+1];
    if (div_q) begin
      hi_d = ge ? s[WIDTH-1:0] : x[WIDTH-1:0];
      lo_d = {lo_q[WIDTH-2:0], ge};
    end else begin
      hi_d = s[WIDTH:1];
      lo_d = {s[0], lo_q[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q   <= '0;
      lo_q   <= '0;
      b_q    <= '0;
      div_q  <= 1'b0;
      busy_q <= 1'b0;
      cnt_q  <= '0;
    end else if (start) begin
      hi_q   <= '0;
      lo_q   <= a;
      b_q    <= b;
      div_q  <= is_div;
      busy_q <= 1'b1;
      cnt_q  <= '0;
    end else if (busy_q) begin
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      cnt_q <= cnt_q + CNT_W'(1);
      if (done) busy_q <= 1'b0;
    end
  end

  assign busy       = busy_q;
  assign done       = busy_q && (cnt_q == CNT_W'(WIDTH - 1));
  assign product_lo = lo_d;
  assign product_hi = hi_d;
  assign quotient   = lo_d;

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU top: handshake FSM, single-cycle datapath, flags and the
// iterative multiply/divide unit. One operation in flight at a time.
module alu_mc
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             flag_zero,
  output logic             flag_carry,
  output logic             flag_ovf
);

  state_t              state_q;
  logic [2:0]          op_q;
  logic [WIDTH-1:0]    result_q;
  logic [FLAG_W-1:0]   flags_q;
  logic                in_ready_q, out_valid_q;

  logic [WIDTH:0]      sum, diff;
  logic [WIDTH-1:0]    alu_res, iter_res;
  logic                alu_carry, alu_ovf, iter_ovf, use_iter, iter_start;
  logic                iter_busy, iter_done;
  logic [WIDTH-1:0]    product_lo, product_hi, quotient;

  always_comb begin
    sum       = {1'b0, a} + {1'b0, b};
    diff      = {1'b0, a} - {1'b0, b};
    alu_res   = '0;
    alu_carry = 1'b0;
    alu_ovf   = 1'b0;
    case (op)
      OP_AND: alu_res = a & b;
      OP_OR:  alu_res = a | b;
      OP_XOR: alu_res = a ^ b;
      OP_ADD: begin
        alu_res   = sum[WIDTH-1:0];
        alu_carry = sum[WIDTH];
        alu_ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res   = diff[WIDTH-1:0];
        alu_carry = ~diff[WIDTH];
        alu_ovf   = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SLT: alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      // Only reached for divide-by-zero; a non-zero divisor takes the iterative path.
      OP_DIV: begin
        alu_res = '1;
        alu_ovf = 1'b1;
      end
      default: ;
    endcase
  end

  assign use_iter   = (op == OP_MUL) || ((op == OP_DIV) && (b != '0));
  assign iter_start = (state_q == ST_IDLE) && in_valid && use_iter;
  assign iter_res   = (op_q == OP_DIV) ? quotient : product_lo;
  assign iter_ovf   = (op_q == OP_MUL) && (product_hi != '0);

  alu_muldiv_iter #(
    .WIDTH(WIDTH),
    .CNT_W(CNT_W)
  ) u_iter (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (iter_start),
    .is_div    (op == OP_DIV),
    .a         (a),
    .b         (b),
    .busy      (iter_busy),
    .done      (iter_done),
    .product_lo(product_lo),
    .product_hi(product_hi),
    .quotient  (quotient)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_AND;
      result_q    <= '0;
      flags_q     <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            op_q       <= op;
            in_ready_q <= 1'b0;
            if (use_iter) begin
              state_q <= ST_BUSY;
            end else begin
              result_q    <= alu_res;
              flags_q     <= pack_flags(alu_res == '0, alu_carry, alu_ovf);
              out_valid_q <= 1'b1;
              state_q     <= ST_DONE;
            end
          end
        end
        ST_BUSY: begin
          if (iter_busy && iter_done) begin
            result_q    <= iter_res;
            flags_q     <= pack_flags(iter_res == '0, 1'b0, iter_ovf);
            out_valid_q <= 1'b1;
            state_q     <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign result     = result_q;
  assign flag_zero  = flags_q[FLAG_ZERO];
  assign flag_carry = flags_q[FLAG_CARRY];
  assign flag_ovf   = flags_q[FLAG_OVF];

endmodule

// File: doc/alu_mc.md
Name: alu_mc

Overview:
- Parametrised multi-cycle ALU; successor to the 32-bit combinational ALU.
- Operand width is generic, and operands and results move over valid/ready handshakes.
- Adds status flags and iterative multiply and divide operations.
- Sits between the operand-issue logic and the writeback stage; one operation in flight at a time.

Parameters:
- WIDTH, 32, operand and result width in bits (legal range 4..64).
- CNT_W, $clog2(WIDTH)+1, width of the iteration counter (derived; do not override).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  a, b and op are valid.
- in_ready  out  1  block can accept an operation.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- op  in  3  operation code.
- out_valid  out  1  result and flags are valid.
- out_ready  in  1  consumer accepts the result.
- result  out  WIDTH  operation result.
- flag_zero  out  1  result equals zero.
- flag_carry  out  1  unsigned carry / no-borrow.
- flag_ovf  out  1  signed overflow, multiply overflow, or divide-by-zero.

Behaviour:
- Clock and reset: one clock (clk); reset rst_n is asynchronous, active-low.
- Reset: state=IDLE, in_ready=1, out_valid=0, result=0, all flags=0, counter=0.
- Reset mid-operation aborts the operation; no stale result is ever presented.
- Op encoding:
  - 0 AND, 1 OR, 2 ADD, 3 SUB, 4 XOR.
  - 5 SLT: signed; result is 1 or 0.
  - 6 MUL: unsigned; result is the low WIDTH bits.
  - 7 DIV: unsigned; result is the quotient.
- FSM states: IDLE, BUSY, DONE.
- IDLE: in_ready=1.
  - Accept when in_valid && in_ready; latch a, b and op.
  - Ops 0-5, or DIV with b==0: compute, register result and flags, go to DONE.
  - MUL, or DIV with b!=0: load the iterator, counter=0, go to BUSY.
- BUSY: in_ready=0; one shift-add or restoring-divide step per cycle.
  - After exactly WIDTH steps, register result and flags, go to DONE.
- DONE: out_valid=1; result and flags held stable.
  - On out_ready=1: out_valid drops next cycle and state returns to IDLE.
  - in_ready=0 in DONE; in_valid is ignored.
- Latency (accept edge = cycle 0):
  - Single-cycle ops: out_valid=1 in cycle 1.
  - MUL and DIV: out_valid=1 in cycle WIDTH+1.
  - Minimum issue interval is 2 cycles.
- Flags:
  - flag_zero = (result==0) for every op.
  - flag_carry:
    - ADD: carry out of bit WIDTH-1.
    - SUB: 1 when a>=b unsigned.
    - All other ops: 0.
  - flag_ovf:
    - ADD/SUB: signed overflow.
    - MUL: 1 if the high WIDTH bits of the full product are non-zero.
    - DIV by zero: result = all ones, flag_ovf=1.
    - All other ops: 0.
- Arithmetic:
  - ADD/SUB use WIDTH+1-bit internal sums; wrap-around is modulo 2^WIDTH.
  - The MUL accumulator is 2*WIDTH bits.
  - DIV keeps a WIDTH+1-bit partial remainder; the remainder is discarded.
- Simultaneous events:
  - out_ready asserted in the same cycle DONE is entered is honoured; result is consumed that edge.
  - in_valid held during BUSY/DONE is not accepted until IDLE.

Decomposition:
- Package alu_pkg holds:
  - op code localparams (OP_AND..OP_DIV);
  - the FSM state enum (ST_IDLE, ST_BUSY, ST_DONE);
  - flag bit positions.
- Sub-module alu_muldiv_iter is the natural split.
  - Shared shift register and adder for shift-add MUL and restoring DIV.
  - Ports: clk, rst_n, start, is_div, a, b, busy, done, product_lo, product_hi, quotient.
  - Top level keeps the FSM, single-cycle datapath, flags and handshake.

Test Plan:
- ADD a=0xFFFFFFFF b=0x00000001 -> result 0x00000000, zero=1, carry=1, ovf=0, out_valid in cycle 1.
- ADD a=0x7FFFFFFF b=0x00000001 -> result 0x80000000, ovf=1, carry=0.
- SUB a=3 b=5 -> result 0xFFFFFFFE, carry=0.
- SLT a=0xFFFFFFFF b=1 -> result 1.
- MUL a=0x00010000 b=0x00010000 -> result 0, zero=1, ovf=1, out_valid exactly in cycle 33.
- MUL a=12345 b=678 -> result 8369910, ovf=0.
- DIV a=100 b=7 -> result 14 in cycle 33.
- DIV a=5 b=0 -> result 0xFFFFFFFF, ovf=1, out_valid in cycle 1.
- Backpressure:
  - Stimulus: out_ready=0 for 5 cycles after an OR result, with in_valid=1 and new operands applied.
  - Response: result stable, in_ready=0, nothing accepted.
  - Then out_ready=1 -> IDLE next cycle, new op accepted the cycle after.
- Reset mid-MUL:
  - Stimulus: rst_n=0 at cycle 10.
  - Response: out_valid=0 and in_ready=1 immediately (asynchronous).
  - After release, ADD 2+2 returns 4 in cycle 1.
